inst_fetch_buffer: RTL and testbench
====================================

// Module: inst_fetch_buffer
// PURPOSE
//  Parametrised instruction prefetch queue; replaces the direct pc_reg -> if_id path of the pipeline top.
//  Issues sequential fetches to the instruction ROM and buffers DEPTH {pc,inst} pairs.
//  Delivers them to decode over a valid/ready handshake; flushes on ID-stage branch redirect.
//  Decouples fetch from decode/ctrl stalls so the ROM keeps streaming while ID stalls.
// PARAMETERS
//  DEPTH     4      queue entries; power of two, >= 2
//  ADDR_W    32     instruction address width
//  DATA_W    32     instruction word width
//  RESET_PC  32'h0  first fetch address after reset
//  PC_STEP   4      address increment per sequential fetch
// PORTS
//  clk                      in   1                    clock; all state updates on posedge
//  rst                      in   1                    reset; synchronous, active-high
//  rom_data_i               in   DATA_W               ROM word for rom_addr_o; combinational, same cycle
//  rom_addr_o               out  ADDR_W               fetch address (= fetch_pc)
//  rom_ce_o                 out  1                    ROM enable; a push happens every cycle this is 1
//  branch_flag_i            in   1                    ID-stage taken branch/jump this cycle
//  branch_target_address_i  in   ADDR_W               redirect target
//  stall_i                  in   1                    ctrl stall for the IF/ID boundary; blocks pop
//  id_ready_i               in   1                    decode accepts the head entry
//  id_valid_o               out  1                    head entry valid
//  id_pc_o                  out  ADDR_W               head pc (0 when empty)
//  id_inst_o                out  DATA_W               head inst (0 when empty)
//  count_o                  out  $clog2(DEPTH+1)      occupied entries
//  full_o / empty_o         out  1                    count_o == DEPTH / count_o == 0
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC, ce_q=0, count=0, rd/wr ptr=0. Outputs: id_valid_o=0, id_pc_o=0,
//    id_inst_o=0, rom_ce_o=0, empty_o=1, full_o=0. Reset mid-operation discards all entries and any redirect.
//  - ce_q goes to 1 on the first cycle after rst deasserts.
//  - rom_ce_o = ce_q & ~full_o. Full is evaluated before the pop, so there is no same-cycle bypass and no
//    path from id_ready_i to the ROM.
//  - Push: when rom_ce_o=1, write {fetch_pc, rom_data_i} at wr_ptr. fetch_pc += PC_STEP, wrapping mod 2^ADDR_W.
//  - Pop: pop = id_valid_o & id_ready_i & ~stall_i. Advances rd_ptr. Push and pop in the same cycle leave count unchanged.
//  - Head outputs are combinational from rd_ptr. Latency ROM->ID is 1 cycle minimum.
//  - Pointers are log2(DEPTH) bits and wrap naturally. count is tracked separately so full and empty are distinguishable.
//  - Redirect (branch_flag_i=1): next fetch_pc = branch_target_address_i, overriding the +PC_STEP.
//    Queue contents after the cycle are set by the optional feature (below). The target is never pushed in the redirect cycle.
//  - Redirect while stall_i=1: the redirect is still applied; the retention rule is unchanged.
//  - Unaligned targets are passed through unchecked.
// CONFIGURATION
//  IFB_DELAY_SLOT_EN defined:
//    - on redirect, keep exactly one entry: the oldest entry surviving this cycle's pop, counting a same-cycle push.
//    - that entry is the MIPS delay slot. All younger entries are discarded.
//    - if nothing survives, the queue empties. The next ID instruction is then the first fetch at the target.
//  IFB_DELAY_SLOT_EN undefined:
//    - on redirect, count <= 0 and the same-cycle push is dropped.
//    - the delay slot is the responsibility of the issuing stage.
// STRUCTURE
//  - defines.v constants: RstEnable, ChipEnable/ChipDisable, InstAddrBus, InstBus, ZeroWord.
//  - New in defines.v: IfbDepth, IfbCntBus.
//  - Sub-module ifb_fifo: circular storage with ptrs/count, plus a flush-keep-one input.
//  - Top-level logic: fetch_pc, ce, and redirect control.
// TESTING
//  1 Reset then stream, DEPTH=4, id_ready_i=1:
//    - rom_addr_o goes 0,4,8,...
//    - id_pc_o goes 0,4,8,... one cycle behind, with id_valid_o continuous from cycle 2.
//  2 id_ready_i=0 for 6 cycles:
//    - count_o climbs to 4, full_o=1, rom_ce_o=0, rom_addr_o holds 0x10.
//    - on release, pops 0,4,8,C in order with no loss or duplication.
//  3 stall_i=1 with id_ready_i=1:
//    - no pop, id_pc_o held.
//    - on stall_i drop, the same entry is accepted once.
//  4 Redirect, DS_EN undefined:
//    - branch_flag_i=1, target 0x100, queue {8,C}.
//    - next cycle count_o=0. Following cycle id_pc_o=0x100.
//  5 Redirect, DS_EN defined, queue {8,C}, pop of 8 in the same cycle:
//    - C retained, count_o=1.
//    - ID sees C, then 0x100, 0x104.
//  6 Mid-operation and wrap cases:
//    - rst asserted with the queue full: next cycle count_o=0, id_valid_o=0, rom_ce_o=0, rom_addr_o=RESET_PC.
//    - wrap: fetch at 0xFFFFFFFC gives next rom_addr_o=0x0.

Source files
------------

// File: rtl/inst_fetch_buffer_pkg.sv
// Shared constants for the instruction fetch buffer (legacy defines.v values plus queue sizing).
package inst_fetch_buffer_pkg;

    localparam logic        RstEnable   = 1'b1;
    localparam logic        ChipEnable  = 1'b1;
    localparam logic        ChipDisable = 1'b0;
    localparam int unsigned InstAddrBus = 32;
    localparam int unsigned InstBus     = 32;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    localparam int unsigned IfbDepth    = 4;
    localparam int unsigned IfbCntBus   = $clog2(IfbDepth + 1);

endpackage

// File: rtl/inst_fetch_buffer_fifo.sv
// Circular {pc,inst} storage with separate occupancy count and a redirect flush
// that can optionally retain the single oldest surviving entry.
module inst_fetch_buffer_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 64,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic             i_keep_one,
    input  logic [W-1:0]     i_wdata,
    output logic [W-1:0]     o_rdata,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_survivor;

    // Next read pointer / occupancy assuming no flush; drives both normal and flush updates.
    always_comb begin
        w_rd_ptr_nxt = i_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
        w_count_nxt  = r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        w_survivor   = (w_count_nxt != '0);
    end

    // Storage write; a push in a keep-one flush cycle lands at the slot that becomes the head when nothing older survives.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and count update with flush handling.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush && i_keep_one) begin
            r_rd_ptr <= w_rd_ptr_nxt;
            r_wr_ptr <= w_survivor ? w_rd_ptr_nxt + PTR_W'(1) : w_rd_ptr_nxt;
            r_count  <= w_survivor ? CNT_W'(1) : '0;
        end else if (i_flush) begin
            r_rd_ptr <= w_rd_ptr_nxt;
            r_wr_ptr <= w_rd_ptr_nxt;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= w_rd_ptr_nxt;
            r_wr_ptr <= i_push ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
            r_count  <= w_count_nxt;
        end
    end

    // Head entry and status, zeroed when empty.
    always_comb begin
        o_valid = (r_count != '0);
        o_rdata = o_valid ? r_mem[r_rd_ptr] : '0;
        o_count = r_count;
        o_full  = (r_count == CNT_W'(DEPTH));
        o_empty = (r_count == '0);
    end

endmodule

// File: rtl/inst_fetch_buffer.sv
// Instruction prefetch queue between the ROM and the ID stage.
// Optional feature macro: IFB_DELAY_SLOT_EN (redirect keeps the oldest surviving entry as the delay slot).
module inst_fetch_buffer
    import inst_fetch_buffer_pkg::*;
#(
    parameter int unsigned              DEPTH    = IfbDepth,
    parameter int unsigned              ADDR_W   = InstAddrBus,
    parameter int unsigned              DATA_W   = InstBus,
    parameter logic [ADDR_W-1:0]        RESET_PC = ADDR_W'(ZeroWord),
    parameter int unsigned              PC_STEP  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            rom_data_i,
    output logic [ADDR_W-1:0]            rom_addr_o,
    output logic                         rom_ce_o,
    input  logic                         branch_flag_i,
    input  logic [ADDR_W-1:0]            branch_target_address_i,
    input  logic                         stall_i,
    input  logic                         id_ready_i,
    output logic                         id_valid_o,
    output logic [ADDR_W-1:0]            id_pc_o,
    output logic [DATA_W-1:0]            id_inst_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

    logic [ADDR_W-1:0]  r_fetch_pc;
    logic               r_ce;

    logic               w_full;
    logic               w_valid;
    logic               w_rom_ce;
    logic               w_push;
    logic               w_pop;
    logic               w_keep_one;
    logic [ENTRY_W-1:0] w_head;

    // Fetch enable, push/pop qualification and redirect retention mode.
    always_comb begin
        w_rom_ce = r_ce & ~w_full;
        w_pop    = w_valid & id_ready_i & ~stall_i;
`ifdef IFB_DELAY_SLOT_EN
        w_push     = w_rom_ce;
        w_keep_one = 1'b1;
`else
        w_push     = w_rom_ce & ~branch_flag_i;
        w_keep_one = 1'b0;
`endif
    end

    // Fetch address and ROM enable; redirect overrides the sequential step.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_fetch_pc <= RESET_PC;
            r_ce       <= ChipDisable;
        end else begin
            r_ce <= ChipEnable;
            if (branch_flag_i) begin
                r_fetch_pc <= branch_target_address_i;
            end else if (w_rom_ce) begin
                r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
            end
        end
    end

    inst_fetch_buffer_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W),
        .CNT_W (CNT_W)
    ) u_ifb_fifo (
        .clk        (clk),
        .i_rst      (rst),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_flush    (branch_flag_i),
        .i_keep_one (w_keep_one),
        .i_wdata    ({r_fetch_pc, rom_data_i}),
        .o_rdata    (w_head),
        .o_valid    (w_valid),
        .o_count    (count_o),
        .o_full     (w_full),
        .o_empty    (empty_o)
    );

    // Output mapping.
    always_comb begin
        rom_addr_o = r_fetch_pc;
        rom_ce_o   = w_rom_ce;
        full_o     = w_full;
        id_valid_o = w_valid;
        id_pc_o    = w_head[ENTRY_W-1:DATA_W];
        id_inst_o  = w_head[DATA_W-1:0];
    end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Self-checking bench for inst_fetch_buffer: directed scenarios plus randomized traffic against a queue model.
module tb_inst_fetch_buffer;
    import inst_fetch_buffer_pkg::*;

    localparam int unsigned DEPTH = IfbDepth;
    localparam int unsigned CW    = IfbCntBus;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   rom_data;
    logic [31:0]   rom_addr;
    logic          rom_ce;
    logic          branch = 1'b0;
    logic [31:0]   target = 32'h0;
    logic          stall  = 1'b0;
    logic          ready  = 1'b1;
    logic          id_valid;
    logic [31:0]   id_pc;
    logic [31:0]   id_inst;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign rom_data = rom_word(rom_addr);

    inst_fetch_buffer dut (
        .clk                     (clk),
        .rst                     (rst),
        .rom_data_i              (rom_data),
        .rom_addr_o              (rom_addr),
        .rom_ce_o                (rom_ce),
        .branch_flag_i           (branch),
        .branch_target_address_i (target),
        .stall_i                 (stall),
        .id_ready_i              (ready),
        .id_valid_o              (id_valid),
        .id_pc_o                 (id_pc),
        .id_inst_o               (id_inst),
        .count_o                 (count),
        .full_o                  (full),
        .empty_o                 (empty)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of {pc,inst}, the next fetch address and the fetch-enable flag.
    logic [63:0] mq[$];
    logic [31:0] m_pc = 32'h0;
    bit          m_ce = 1'b0;
    bit          m_ok = 1'b0;

    task automatic model_step();
        bit push;
        bit pop;
        if (rst) begin
            mq.delete();
            m_pc = 32'h0;
            m_ce = 1'b0;
            m_ok = 1'b1;
            return;
        end
        push = m_ce && (mq.size() < int'(DEPTH));
        pop  = (mq.size() != 0) && ready && !stall;
        if (pop) void'(mq.pop_front());
        if (branch) begin
`ifdef IFB_DELAY_SLOT_EN
            if (push) mq.push_back({m_pc, rom_word(m_pc)});
            while (mq.size() > 1) void'(mq.pop_back());
`else
            mq.delete();
`endif
            m_pc = target;
        end else if (push) begin
            mq.push_back({m_pc, rom_word(m_pc)});
            m_pc = m_pc + 32'd4;
        end
        m_ce = 1'b1;
    endtask

    // Every cycle: compare DUT against the model, then advance the model with this cycle's inputs.
    always @(negedge clk) begin
        if (m_ok) begin
            chk("m_valid", 64'(id_valid), 64'(mq.size() != 0));
            chk("m_pc",    64'(id_pc),    (mq.size() != 0) ? 64'(mq[0][63:32]) : 64'h0);
            chk("m_inst",  64'(id_inst),  (mq.size() != 0) ? 64'(mq[0][31:0])  : 64'h0);
            chk("m_count", 64'(count),    64'(mq.size()));
            chk("m_full",  64'(full),     64'(mq.size() == int'(DEPTH)));
            chk("m_empty", 64'(empty),    64'(mq.size() == 0));
            chk("m_ce",    64'(rom_ce),   64'(m_ce && (mq.size() < int'(DEPTH))));
            chk("m_addr",  64'(rom_addr), 64'(m_pc));
        end
        model_step();
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        // Reset state and streaming start
        chk("rst_ce",    64'(rom_ce),   64'h0);
        chk("rst_addr",  64'(rom_addr), 64'h0);
        chk("rst_valid", 64'(id_valid), 64'h0);
        chk("rst_empty", 64'(empty),    64'h1);
        chk("rst_count", 64'(count),    64'h0);
        step(1);
        chk("s1_ce1",    64'(rom_ce),   64'h1);
        chk("s1_valid0", 64'(id_valid), 64'h0);
        step(1);
        chk("s1_pc0",    64'(id_pc),    64'h0);
        chk("s1_addr4",  64'(rom_addr), 64'h4);
        step(1);
        chk("s1_pc4",    64'(id_pc),    64'h4);
        chk("s1_addr8",  64'(rom_addr), 64'h8);

        // Backpressure fills the queue
        rst = 1'b1; step(1); rst = 1'b0; ready = 1'b0;
        step(6);
        chk("s2_count",  64'(count),    64'h4);
        chk("s2_full",   64'(full),     64'h1);
        chk("s2_ce",     64'(rom_ce),   64'h0);
        chk("s2_addr",   64'(rom_addr), 64'h10);
        ready = 1'b1;
        chk("s2_pop0",   64'(id_pc),    64'h0);
        step(1); chk("s2_pop4", 64'(id_pc), 64'h4);
        step(1); chk("s2_pop8", 64'(id_pc), 64'h8);
        step(1); chk("s2_popC", 64'(id_pc), 64'hC);
        step(1); chk("s2_pop10", 64'(id_pc), 64'h10);

        // Stall holds the head
        stall = 1'b1;
        step(3);
        chk("s3_hold",   64'(id_pc),    64'h10);
        chk("s3_count",  64'(count),    64'h4);
        stall = 1'b0;
        step(1);
        chk("s3_next",   64'(id_pc),    64'h14);
        chk("s3_cnt3",   64'(count),    64'h3);

        // Redirect with queue {8,C} and a same-cycle pop of 8
        rst = 1'b1; step(1); rst = 1'b0; ready = 1'b0;
        step(3);
        ready = 1'b1;
        step(2);
        chk("s4_head8",  64'(id_pc),    64'h8);
        chk("s4_cnt2",   64'(count),    64'h2);
        branch = 1'b1; target = 32'h100;
        step(1);
        branch = 1'b0;
        chk("s4_addr",   64'(rom_addr), 64'h100);
`ifdef IFB_DELAY_SLOT_EN
        chk("s5_cnt1",   64'(count),    64'h1);
        chk("s5_slotC",  64'(id_pc),    64'hC);
`else
        chk("s4_cnt0",   64'(count),    64'h0);
        chk("s4_valid0", 64'(id_valid), 64'h0);
`endif
        step(1); chk("s4_tgt",  64'(id_pc), 64'h100);
        step(1); chk("s4_tgt4", 64'(id_pc), 64'h104);

        // Reset while full, then address wrap
        ready = 1'b0;
        step(6);
        chk("s6_full",   64'(full),     64'h1);
        rst = 1'b1; step(1); rst = 1'b0;
        chk("s6_cnt",    64'(count),    64'h0);
        chk("s6_valid",  64'(id_valid), 64'h0);
        chk("s6_ce",     64'(rom_ce),   64'h0);
        chk("s6_addr",   64'(rom_addr), 64'h0);
        ready = 1'b1;
        step(2);
        branch = 1'b1; target = 32'hFFFF_FFFC;
        step(1);
        branch = 1'b0;
        chk("s6_wrapA",  64'(rom_addr), 64'hFFFF_FFFC);
        step(1);
        chk("s6_wrapB",  64'(rom_addr), 64'h0);

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            rst    = ($urandom % 300) == 0;
            ready  = ($urandom % 4) != 0;
            stall  = ($urandom % 5) == 0;
            branch = ($urandom % 12) == 0;
            target = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : $urandom;
            step(1);
        end
        rst = 1'b0; branch = 1'b0; stall = 1'b0; ready = 1'b1;
        step(3);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
